// File: rtl/ncc_pkg.sv
// Shared types and word widths for the NCC systolic-array sequencer.
package ncc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_DESC, STREAM, DONE} ncc_seq_state_t;
  localparam int LOG_W = 33;
  localparam int ACC_W = 8;
endpackage

// File: rtl/ncc_beat_counter.sv
// Clearable up-counter used for descriptor, window and result beat counts.
module ncc_beat_counter #(
  parameter int MAX = 255,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (en)      count <= count + W'(1);
  end
endmodule

// File: rtl/ncc_array_sequencer.sv
// Sequencer for the log-domain NCC PE chain: descriptor load, window streaming
// with per-beat PE strobes, and a one-deep result register fed from the tail PE.
module ncc_array_sequencer
  import ncc_pkg::*;
#(
  parameter int NUM_PE      = 16,
  parameter int DESC_PIXELS = 256,
  parameter int WIN_PIXELS  = 640,
  parameter int LW          = LOG_W,
  parameter int AW          = ACC_W,
  parameter int DA_W        = $clog2(DESC_PIXELS),
  parameter int RI_W        = $clog2(WIN_PIXELS),
  parameter int WC_W        = $clog2(WIN_PIXELS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            reuse_desc,
  output logic            busy,
  output logic            done,
  input  logic            desc_valid,
  output logic            desc_ready,
  input  logic [LW-1:0]   desc_data,
  output logic            desc_wr_en,
  output logic [DA_W-1:0] desc_wr_addr,
  output logic [LW-1:0]   desc_wr_data,
  input  logic            win_valid,
  output logic            win_ready,
  output logic            load_win_reg,
  output logic            load_acc_sum_reg,
  input  logic [AW-1:0]   acc_last,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [AW-1:0]   result_data,
  output logic [RI_W-1:0] result_idx
);
  ncc_seq_state_t state, state_n;
  logic            cap_pending;
  logic [WC_W-1:0] win_cnt;
  logic [RI_W-1:0] res_cnt;
  logic            idle, out_free, beat, qual, capture;

  assign idle     = (state == IDLE);
  assign out_free = !result_valid || result_ready;
  assign capture  = cap_pending && out_free;

  assign busy       = !idle;
  assign done       = (state == DONE);
  assign desc_ready = (state == LOAD_DESC);
  assign desc_wr_en = desc_valid && desc_ready;
  // Gated so the write-data port reads zero outside a descriptor load.
  assign desc_wr_data = desc_ready ? desc_data : '0;

  assign win_ready = (state == STREAM) && (win_cnt < WC_W'(WIN_PIXELS)) &&
                     (!cap_pending || out_free);
  assign beat             = win_valid && win_ready;
  assign load_win_reg     = beat;
  assign load_acc_sum_reg = beat;
  // Tail PE holds a valid sum once the chain has been filled.
  assign qual = beat && (win_cnt >= WC_W'(NUM_PE - 1));

  ncc_beat_counter #(.MAX(DESC_PIXELS - 1), .W(DA_W)) u_desc_cnt (
    .clk(clk), .rst(rst), .clear(idle), .en(desc_wr_en), .count(desc_wr_addr));
  ncc_beat_counter #(.MAX(WIN_PIXELS), .W(WC_W)) u_win_cnt (
    .clk(clk), .rst(rst), .clear(idle), .en(beat), .count(win_cnt));
  ncc_beat_counter #(.MAX(WIN_PIXELS - NUM_PE + 1), .W(RI_W)) u_res_cnt (
    .clk(clk), .rst(rst), .clear(idle), .en(capture), .count(res_cnt));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = reuse_desc ? STREAM : LOAD_DESC;
      LOAD_DESC: if (desc_wr_en && desc_wr_addr == DA_W'(DESC_PIXELS - 1)) state_n = STREAM;
      STREAM:    if (win_cnt == WC_W'(WIN_PIXELS) && !cap_pending && !result_valid)
                   state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cap_pending  <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_idx   <= '0;
    end else begin
      state       <= state_n;
      cap_pending <= qual || (cap_pending && !capture);
      if (capture) begin
        result_valid <= 1'b1;
        result_data  <= acc_last;
        result_idx   <= res_cnt;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ncc_array_sequencer.sv
// Directed bench for ncc_array_sequencer: vector table plus full-job sequences.
module tb_ncc_array_sequencer;
  import ncc_pkg::*;
  localparam int NRES = 625;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, reuse_desc = 1'b0;
  logic desc_valid = 1'b0, win_valid = 1'b0, result_ready = 1'b0;
  logic [LOG_W-1:0] desc_data = '0;
  logic [ACC_W-1:0] acc_last;
  logic busy, done, desc_ready, desc_wr_en, win_ready, load_win_reg, load_acc_sum_reg;
  logic result_valid;
  logic [7:0] desc_wr_addr;
  logic [LOG_W-1:0] desc_wr_data;
  logic [ACC_W-1:0] result_data;
  logic [9:0] result_idx;

  always #5 clk = ~clk;

  ncc_array_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .reuse_desc(reuse_desc), .busy(busy), .done(done),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .desc_wr_en(desc_wr_en), .desc_wr_addr(desc_wr_addr), .desc_wr_data(desc_wr_data),
    .win_valid(win_valid), .win_ready(win_ready), .load_win_reg(load_win_reg),
    .load_acc_sum_reg(load_acc_sum_reg), .acc_last(acc_last), .result_valid(result_valid),
    .result_ready(result_ready), .result_data(result_data), .result_idx(result_idx));

  // Tail-PE model: accOut changes only on an accumulator strobe.
  function automatic logic [ACC_W-1:0] acc_f(input int n);
    return ACC_W'(n * 37 + 5);
  endfunction

  int nb = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || (start && !busy)) nb <= 0;
    else if (load_acc_sum_reg)   nb <= nb + 1;
  end
  assign acc_last = acc_f(nb);

  // Per-job observation counters, cleared when a job is launched or on reset.
  int strobe_n = 0, strobe_first = 0, strobe_last = 0, beat15_cyc = -1, first_rv_cyc = -1;
  int res_n = 0, res_bad = 0, done_n = 0, drdy_n = 0, wen_n = 0, strobe_mis = 0;
  always @(negedge clk) begin
    if (rst || (start && !busy)) begin
      strobe_n <= 0; strobe_first <= 0; strobe_last <= 0; beat15_cyc <= -1;
      first_rv_cyc <= -1; res_n <= 0; res_bad <= 0; done_n <= 0; drdy_n <= 0;
      wen_n <= 0; strobe_mis <= 0;
    end else begin
      if (load_win_reg != load_acc_sum_reg) strobe_mis <= strobe_mis + 1;
      if (load_win_reg) begin
        if (strobe_n == 0)  strobe_first <= cyc;
        if (strobe_n == 15) beat15_cyc <= cyc;
        strobe_last <= cyc;
        strobe_n <= strobe_n + 1;
      end
      if (result_valid && first_rv_cyc < 0) first_rv_cyc <= cyc;
      if (result_valid && result_ready) begin
        if (int'(result_idx) != res_n || result_data != acc_f(16 + res_n)) res_bad <= res_bad + 1;
        res_n <= res_n + 1;
      end
      if (done)       done_n <= done_n + 1;
      if (desc_ready) drdy_n <= drdy_n + 1;
      if (desc_wr_en) wen_n <= wen_n + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_to_done(input string nm);
    int n;
    n = 0;
    #1;
    while (!done && n < 3000) begin
      tick(); #1; n++;
    end
    chk(nm, 32'(done), 32'd1);
    tick(); tick();
  endtask

  function automatic logic [7:0] flags();
    return {busy, done, desc_ready, desc_wr_en, win_ready, load_win_reg, load_acc_sum_reg,
            result_valid};
  endfunction

  typedef struct {
    logic rst, start, reuse, dv, wv, rr;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[11];
    int bad, gap, n, sn;
    logic [ACC_W-1:0] snap;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b1000_1110};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b1000_1110};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b0000_0000};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b1010_0000};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1011_0000};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b1011_0000};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000};

    tick();
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; reuse_desc = tbl[i].reuse;
      desc_valid = tbl[i].dv; win_valid = tbl[i].wv; result_ready = tbl[i].rr;
      #1;
      chk($sformatf("vec%0d", i), 32'(flags()), 32'(tbl[i].exp));
      tick();
    end
    chk("rst_result_regs", {12'd0, result_idx, result_data, desc_wr_addr}, 32'd0);

    // Job 1: descriptor load with random gaps, then an unthrottled stream.
    reuse_desc = 1'b0; start = 1'b1; tick(); start = 1'b0; #1;
    chk("ld_enter", 32'({busy, desc_ready, desc_wr_en}), 32'b110);
    bad = 0;
    tick();
    for (int w = 0; w < 256; w++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin desc_valid = 1'b0; tick(); end
      desc_valid = 1'b1;
      desc_data = LOG_W'({$urandom, $urandom});
      #1;
      if (!desc_wr_en || desc_wr_addr != 8'(w) || desc_wr_data != desc_data) bad++;
      tick();
    end
    desc_valid = 1'b0; #1;
    chk("desc_beats_bad", 32'(bad), 32'd0);
    chk("stream_entered", 32'({busy, desc_ready, win_ready}), 32'b101);
    chk("desc_wr_en_count", 32'(wen_n), 32'd256);
    win_valid = 1'b1; result_ready = 1'b1;
    run_to_done("job1_done");
    chk("job1_strobes", 32'(strobe_n), 32'd640);
    chk("job1_consecutive", 32'(strobe_last - strobe_first + 1), 32'd640);
    chk("job1_first_latency", 32'(first_rv_cyc - beat15_cyc), 32'd2);
    chk("job1_results", 32'(res_n), 32'(NRES));
    chk("job1_result_bad", 32'(res_bad), 32'd0);
    chk("job1_done_pulses", 32'(done_n), 32'd1);
    chk("job1_strobe_pair", 32'(strobe_mis), 32'd0);
    chk("job1_idle", 32'(busy), 32'd0);

    // Job 2: reuse descriptors, result backpressure mid-stream.
    win_valid = 1'b0; reuse_desc = 1'b1; start = 1'b1; tick(); start = 1'b0; reuse_desc = 1'b0; #1;
    chk("reuse_direct_stream", 32'({busy, desc_ready, win_ready}), 32'b101);
    win_valid = 1'b1; result_ready = 1'b1;
    n = 0;
    while (strobe_n < 100 && n < 1000) begin tick(); #1; n++; end
    result_ready = 1'b0;
    chk("bp_rv_at_stall", 32'(result_valid), 32'd1);
    tick(); #1;
    chk("bp_win_ready", 32'(win_ready), 32'd0);
    snap = result_data; sn = strobe_n;
    repeat (8) tick();
    #1;
    chk("bp_hold_data", 32'(result_data), 32'(snap));
    chk("bp_no_strobe", 32'(strobe_n), 32'(sn));
    chk("bp_rv_held", 32'(result_valid), 32'd1);
    result_ready = 1'b1;
    run_to_done("job2_done");
    chk("job2_results", 32'(res_n), 32'(NRES));
    chk("job2_result_bad", 32'(res_bad), 32'd0);
    chk("job2_no_desc_ready", 32'(drdy_n), 32'd0);
    chk("job2_done_pulses", 32'(done_n), 32'd1);

    // Job 3: reset mid-stream, then a fresh job must run cleanly.
    reuse_desc = 1'b1; start = 1'b1; tick(); start = 1'b0; reuse_desc = 1'b0;
    n = 0; #1;
    while (strobe_n < 300 && n < 1000) begin tick(); #1; n++; end
    chk("midrst_reached", 32'(strobe_n >= 300), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("midrst_flags", 32'(flags()), 32'd0);
    chk("midrst_regs", {12'd0, result_idx, result_data, desc_wr_addr}, 32'd0);
    tick();
    reuse_desc = 1'b1; start = 1'b1; tick(); start = 1'b0; reuse_desc = 1'b0;
    run_to_done("job4_done");
    chk("job4_strobes", 32'(strobe_n), 32'd640);
    chk("job4_results", 32'(res_n), 32'(NRES));
    chk("job4_result_bad", 32'(res_bad), 32'd0);
    chk("job4_done_pulses", 32'(done_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
